apb_req_arbiter: RTL and testbench
==================================

# apb_req_arbiter

Two-port request arbiter in front of the APB master's internal interface (transfer/ready/write/addr/wdata/rdata). It lets two requesters, such as the CPU load/store port and a DMA engine, share one APB master. The arbiter accepts held-level requests and grants one at a time, round-robin or fixed-priority. It sequences the single-cycle `transfer` pulse, tracks the master's SETUP/ACCESS phases, and returns read data with a one-cycle `done` pulse to the granted requester.

## Interface
- `RR_EN`, default 1: 1 selects round-robin; 0 selects fixed priority with port 0 winning.
- `PCLK` input 1: single clock.
- `PRESET` input 1: reset, synchronous and active-high.
- `req0_valid` input 1: port 0 request; held until `req0_done`.
- `req0_write` input 1: port 0 direction, 1 = write; stable while valid.
- `req0_addr` input 32: port 0 address; stable while valid.
- `req0_wdata` input 32: port 0 write data; stable while valid.
- `req0_done` output 1: one-cycle completion pulse.
- `req0_rdata` output 32: read data; valid with `req0_done`, held until the next port 0 completion.
- `req1_valid`, `req1_write`, `req1_addr`, `req1_wdata`, `req1_done`, `req1_rdata`: same as port 0.
- `transfer` output 1: one-cycle start pulse to the APB master.
- `write` output 1: direction to the master.
- `addr` output 32: address to the master.
- `wdata` output 32: write data to the master.
- `ready` input 1: completion from the master (muxed PREADY).
- `rdata` input 32: read data from the master (muxed PRDATA).
- `grant` output 2: one-hot owner of the current transaction; 0 when idle.
- `busy` output 1: high in every state except IDLE.

## Operation
- FSM states: IDLE, ISSUE, SETUP_WAIT, ACCESS_WAIT, DONE.
- IDLE:
  - Samples `req0_valid` and `req1_valid`.
  - If either is set, picks a winner, latches its write/addr/wdata into the master-side registers, sets `grant`, and goes to ISSUE.
- ISSUE:
  - `transfer`=1 for exactly this cycle.
  - Next state is SETUP_WAIT.
- SETUP_WAIT:
  - `ready` is ignored, because the master's PREADY mux is already enabled during SETUP.
  - Next state is ACCESS_WAIT.
- ACCESS_WAIT:
  - Stays here while `ready`=0.
  - On `ready`=1, captures `rdata` into the granted port's rdata register; next state is DONE.
  - Write transactions also capture (don't-care data).
- DONE:
  - The granted port's `done`=1 for this cycle.
  - Updates `last_grant`.
  - Next state is IDLE and `grant` clears.
- Arbitration:
  - RR_EN=1, both valid: the port other than `last_grant` wins. `last_grant` resets to port 1, so port 0 wins the first tie.
  - Only one valid: that port wins.
  - RR_EN=0: port 0 wins whenever it is valid.
- `write`/`addr`/`wdata` stay driven from the latched registers from ISSUE through DONE, and keep their last value in IDLE.
- The arbiter never decodes addresses. Unmapped addresses complete with whatever `ready`/`rdata` the master returns.
- Requester rule: `valid` is re-sampled in the IDLE cycle after `done`.
  - A requester keeping `valid` high after its `done` issues a new request.
  - A requester must drop `valid` in the cycle after `done` if it has no new request.
- Dropping `valid` before `done` is illegal. The arbiter completes the latched transaction regardless.

## Timing
- Reset (PRESET=1 at an edge): state=IDLE, `last_grant`=port 1, and all of the following are 0: `transfer`, `write`, `addr`, `wdata`, `grant`, `busy`, `req0_done`, `req1_done`, `req0_rdata`, `req1_rdata`.
- Reset mid-transaction: abandoned immediately, with no `done` issued. The APB master shares PRESET, so both return to IDLE together.
- Request at cycle t (IDLE) produces:
  - t+1: `transfer`=1.
  - t+2: master SETUP.
  - t+3: first ACCESS cycle.
  - With zero wait states (`ready`=1 at t+3), `done` comes at t+4.
  - Each extra wait cycle adds 1.
- Minimum spacing between `transfer` pulses is 5 cycles (ISSUE→SETUP_WAIT→ACCESS_WAIT→DONE→IDLE→ISSUE). The master is back in IDLE before the next pulse.
- A request arriving while busy waits; it is sampled in the next IDLE cycle.
- `req*_done` are never high simultaneously, and never for more than one cycle.

## Test plan
- Single read, zero wait: port 0 read of 0x1000_1004 at t, master returns `ready`=1 at t+3 with 0xCAFE_0001 → `transfer` at t+1 only, `addr`=0x1000_1004, `write`=0, `req0_done` at t+4, `req0_rdata`=0xCAFE_0001, `grant`=01 for t+1..t+4.
- Wait states and SETUP guard: port 1 write of 0x1000_3000 with data 0x0000_00FF; `ready` forced high at t+2 and low at t+3..t+5, high at t+6 → completion not taken at t+2, `req1_done` at t+7, `wdata`=0x0000_00FF throughout.
- Tie, round-robin: both ports valid from reset and re-requesting after each `done` → grants 01,10,01,10; `done` pulses alternate; `transfer` pulses 5 cycles apart.
- Fixed priority: RR_EN=0, both held valid → port 0 granted every time; port 1 granted only after port 0 drops `valid`.
- Reset mid-ACCESS: assert PRESET during ACCESS_WAIT of a port 0 read → next cycle all outputs 0, no `req0_done`; the next request after reset completes normally.
- Late arrival: port 1 valid raised during port 0's ACCESS_WAIT → port 1 `transfer` issued exactly 2 cycles after `req0_done`, with port 1 address on `addr`.

Source files
------------

// File: rtl/apb_req_arbiter.sv
// Two-port round-robin/fixed-priority arbiter feeding one APB master; request-to-done is 4 cycles plus wait states.
// Requests are held levels: a losing or late requester simply stays valid until it is sampled in a later IDLE cycle.
module apb_req_arbiter #(
  parameter logic RR_EN = 1'b1
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        req0_valid,
  input  logic        req0_write,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wdata,
  output logic        req0_done,
  output logic [31:0] req0_rdata,
  input  logic        req1_valid,
  input  logic        req1_write,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wdata,
  output logic        req1_done,
  output logic [31:0] req1_rdata,
  output logic        transfer,
  output logic        write,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  input  logic        ready,
  input  logic [31:0] rdata,
  output logic [1:0]  grant,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    SETUP_WAIT,
    ACCESS_WAIT,
    DONE
  } state_t;

  state_t state, state_nxt;
  logic   last_grant;   // 1 = port 1 owned the previous transaction
  logic   any_req;
  logic   pick1;

  assign any_req = req0_valid | req1_valid;
  // Port 1 wins when alone, or on a round-robin tie after port 0 was last served
  assign pick1   = req1_valid & (~req0_valid | (RR_EN & ~last_grant));

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    transfer  = 1'b0;
    busy      = 1'b1;
    req0_done = 1'b0;
    req1_done = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (any_req) state_nxt = ISSUE;
      end
      ISSUE: begin
        transfer  = 1'b1;
        state_nxt = SETUP_WAIT;
      end
      // PREADY is already visible during SETUP, so it must not be taken here
      SETUP_WAIT: state_nxt = ACCESS_WAIT;
      ACCESS_WAIT: begin
        if (ready) state_nxt = DONE;
      end
      DONE: begin
        req0_done = grant[0];
        req1_done = grant[1];
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      grant      <= 2'b00;
      last_grant <= 1'b1;
      write      <= 1'b0;
      addr       <= 32'h0;
      wdata      <= 32'h0;
      req0_rdata <= 32'h0;
      req1_rdata <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant <= pick1 ? 2'b10 : 2'b01;
            write <= pick1 ? req1_write : req0_write;
            addr  <= pick1 ? req1_addr  : req0_addr;
            wdata <= pick1 ? req1_wdata : req0_wdata;
          end
        end
        ACCESS_WAIT: begin
          if (ready) begin
            if (grant[1]) req1_rdata <= rdata;
            else          req0_rdata <= rdata;
          end
        end
        DONE: begin
          last_grant <= grant[1];
          grant      <= 2'b00;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Bench for apb_req_arbiter: directed scenarios then randomized traffic against a transaction-level model.
// Instance 0 runs round-robin, instance 1 runs fixed priority.
module tb_apb_req_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        preset [2];
  logic        vld    [2][2];
  logic        wr     [2][2];
  logic [31:0] ad     [2][2];
  logic [31:0] wd     [2][2];
  logic [31:0] rdo    [2][2];
  logic        dn     [2][2];
  logic        xfer   [2];
  logic        mwr    [2];
  logic        rdy    [2];
  logic        bsy    [2];
  logic [31:0] maddr  [2];
  logic [31:0] mwd    [2];
  logic [31:0] mrd    [2];
  logic [1:0]  gnt    [2];

  for (genvar k = 0; k < 2; k++) begin : g_dut
    apb_req_arbiter #(.RR_EN((k == 0) ? 1'b1 : 1'b0)) u_dut (
      .PCLK(clk), .PRESET(preset[k]),
      .req0_valid(vld[k][0]), .req0_write(wr[k][0]), .req0_addr(ad[k][0]),
      .req0_wdata(wd[k][0]), .req0_done(dn[k][0]), .req0_rdata(rdo[k][0]),
      .req1_valid(vld[k][1]), .req1_write(wr[k][1]), .req1_addr(ad[k][1]),
      .req1_wdata(wd[k][1]), .req1_done(dn[k][1]), .req1_rdata(rdo[k][1]),
      .transfer(xfer[k]), .write(mwr[k]), .addr(maddr[k]), .wdata(mwd[k]),
      .ready(rdy[k]), .rdata(mrd[k]), .grant(gnt[k]), .busy(bsy[k])
    );
  end

  int checks = 0;
  int errors = 0;

  // Reference model state: who was served last, and each port's held read data
  int          last_w [2];
  logic [31:0] exp_rd [2][2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick(input int k);
    if (vld[k][0] && vld[k][1]) begin
      if (k == 0) return (last_w[k] == 0) ? 1 : 0;
      return 0;
    end
    return vld[k][0] ? 0 : 1;
  endfunction

  task automatic check_idle(input int k);
    chk("idle_transfer", 32'(xfer[k]), 0);
    chk("idle_busy", 32'(bsy[k]), 0);
    chk("idle_grant", 32'(gnt[k]), 0);
    chk("idle_done", 32'({dn[k][1], dn[k][0]}), 0);
    chk("idle_rdata0", rdo[k][0], exp_rd[k][0]);
    chk("idle_rdata1", rdo[k][1], exp_rd[k][1]);
  endtask

  task automatic do_reset(input int k);
    preset[k] = 1'b1;
    rdy[k]    = 1'b0;
    tick();
    chk("rst_transfer", 32'(xfer[k]), 0);
    chk("rst_write", 32'(mwr[k]), 0);
    chk("rst_addr", maddr[k], 0);
    chk("rst_wdata", mwd[k], 0);
    chk("rst_grant", 32'(gnt[k]), 0);
    chk("rst_busy", 32'(bsy[k]), 0);
    chk("rst_done", 32'({dn[k][1], dn[k][0]}), 0);
    chk("rst_rdata0", rdo[k][0], 0);
    chk("rst_rdata1", rdo[k][1], 0);
    preset[k]    = 1'b0;
    last_w[k]    = 1;
    exp_rd[k][0] = 32'h0;
    exp_rd[k][1] = 32'h0;
  endtask

  // Called in the IDLE cycle where the request is presented; returns in the following IDLE cycle.
  task automatic do_txn(input int k, input int p, input int nwait, input logic setup_rdy,
                        input logic [31:0] rd, input logic late1);
    logic [31:0] ea, ew;
    logic        ewr;
    logic [1:0]  eg;
    ea  = ad[k][p];
    ew  = wd[k][p];
    ewr = wr[k][p];
    eg  = (p == 0) ? 2'b01 : 2'b10;
    tick();
    chk("issue_transfer", 32'(xfer[k]), 1);
    chk("issue_grant", 32'(gnt[k]), 32'(eg));
    chk("issue_addr", maddr[k], ea);
    chk("issue_write", 32'(mwr[k]), 32'(ewr));
    chk("issue_wdata", mwd[k], ew);
    chk("issue_busy", 32'(bsy[k]), 1);
    chk("issue_done", 32'({dn[k][1], dn[k][0]}), 0);
    rdy[k] = 1'b0;
    tick();
    chk("setup_transfer", 32'(xfer[k]), 0);
    chk("setup_grant", 32'(gnt[k]), 32'(eg));
    chk("setup_addr", maddr[k], ea);
    chk("setup_done", 32'({dn[k][1], dn[k][0]}), 0);
    rdy[k] = setup_rdy;
    mrd[k] = $urandom;
    tick();
    for (int i = 0; i <= nwait; i++) begin
      chk("access_transfer", 32'(xfer[k]), 0);
      chk("access_grant", 32'(gnt[k]), 32'(eg));
      chk("access_wdata", mwd[k], ew);
      chk("access_write", 32'(mwr[k]), 32'(ewr));
      chk("access_done", 32'({dn[k][1], dn[k][0]}), 0);
      if (late1 && i == 0) begin
        vld[k][1] = 1'b1;
        wr[k][1]  = 1'b0;
        ad[k][1]  = 32'h2000_0040;
        wd[k][1]  = $urandom;
      end
      rdy[k] = (i == nwait);
      mrd[k] = (i == nwait) ? rd : $urandom;
      tick();
    end
    rdy[k] = 1'b0;
    chk("done_own", 32'(dn[k][p]), 1);
    chk("done_other", 32'(dn[k][1-p]), 0);
    chk("done_rdata", rdo[k][p], rd);
    chk("done_grant", 32'(gnt[k]), 32'(eg));
    chk("done_addr", maddr[k], ea);
    chk("done_transfer", 32'(xfer[k]), 0);
    exp_rd[k][p] = rd;
    last_w[k]    = p;
    tick();
    check_idle(k);
    chk("idle_addr_hold", maddr[k], ea);
    chk("idle_wdata_hold", mwd[k], ew);
  endtask

  initial begin
    int w, prev;
    for (int k = 0; k < 2; k++) begin
      preset[k] = 1'b1;
      rdy[k]    = 1'b0;
      mrd[k]    = 32'h0;
      for (int p = 0; p < 2; p++) begin
        vld[k][p] = 1'b0;
        wr[k][p]  = 1'b0;
        ad[k][p]  = 32'h0;
        wd[k][p]  = 32'h0;
      end
    end
    do_reset(0);
    do_reset(1);

    // Single read, zero wait
    vld[0][0] = 1'b1; wr[0][0] = 1'b0; ad[0][0] = 32'h1000_1004; wd[0][0] = 32'h0;
    do_txn(0, 0, 0, 1'b0, 32'hCAFE_0001, 1'b0);
    vld[0][0] = 1'b0;

    // Write with wait states; ready high during SETUP must be ignored
    vld[0][1] = 1'b1; wr[0][1] = 1'b1; ad[0][1] = 32'h1000_3000; wd[0][1] = 32'h0000_00FF;
    do_txn(0, 1, 3, 1'b1, 32'h1234_5678, 1'b0);
    vld[0][1] = 1'b0;

    // Late arrival: port 1 raised during port 0's ACCESS_WAIT
    vld[0][0] = 1'b1; wr[0][0] = 1'b0; ad[0][0] = 32'h1000_0010;
    do_txn(0, 0, 1, 1'b0, 32'hA5A5_0010, 1'b1);
    vld[0][0] = 1'b0;
    do_txn(0, 1, 0, 1'b0, 32'h5A5A_0040, 1'b0);
    vld[0][1] = 1'b0;

    // Reset in ACCESS_WAIT abandons the read; the held request then completes
    vld[0][0] = 1'b1; wr[0][0] = 1'b0; ad[0][0] = 32'h1000_2000;
    tick();
    tick();
    tick();
    chk("pre_rst_busy", 32'(bsy[0]), 1);
    do_reset(0);
    do_txn(0, 0, 1, 1'b0, 32'hBEEF_2000, 1'b0);
    vld[0][0] = 1'b0;

    // Round-robin tie from reset with continuous re-requests
    vld[0][0] = 1'b1; vld[0][1] = 1'b1;
    ad[0][0] = 32'h1000_0100; ad[0][1] = 32'h1000_0200;
    wr[0][0] = 1'b0; wr[0][1] = 1'b1; wd[0][1] = 32'h0000_0077;
    do_reset(0);
    for (int i = 0; i < 4; i++) do_txn(0, i % 2, 0, 1'b0, 32'hD000_0000 + 32'(i), 1'b0);
    vld[0][0] = 1'b0; vld[0][1] = 1'b0;

    // Fixed priority: port 0 always wins until it drops valid
    vld[1][0] = 1'b1; vld[1][1] = 1'b1;
    ad[1][0] = 32'h3000_0000; ad[1][1] = 32'h3000_0004;
    wr[1][0] = 1'b1; wr[1][1] = 1'b0; wd[1][0] = 32'h1111_2222;
    for (int i = 0; i < 3; i++) do_txn(1, 0, i, 1'b0, 32'hF000_0000 + 32'(i), 1'b0);
    vld[1][0] = 1'b0;
    do_txn(1, 1, 0, 1'b0, 32'hF111_0001, 1'b0);
    vld[1][1] = 1'b0;

    // Randomized traffic against the model, one instance at a time
    for (int k = 0; k < 2; k++) begin
      prev = -1;
      for (int it = 0; it < 40; it++) begin
        for (int p = 0; p < 2; p++) begin
          if (!vld[k][p]) begin
            if (1'($urandom_range(1, 0))) begin
              vld[k][p] = 1'b1;
              wr[k][p]  = 1'($urandom_range(1, 0));
              ad[k][p]  = $urandom;
              wd[k][p]  = $urandom;
            end
          end else if (p == prev) begin
            if ($urandom_range(2, 0) == 0) begin
              vld[k][p] = 1'b0;
            end else begin
              wr[k][p] = 1'($urandom_range(1, 0));
              ad[k][p] = $urandom;
              wd[k][p] = $urandom;
            end
          end
        end
        if (!vld[k][0] && !vld[k][1]) begin
          tick();
          check_idle(k);
          prev = -1;
        end else begin
          w = pick(k);
          do_txn(k, w, int'($urandom_range(3, 0)), 1'($urandom_range(1, 0)), $urandom, 1'b0);
          prev = w;
        end
      end
      vld[k][0] = 1'b0;
      vld[k][1] = 1'b0;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
